inst_mem_responder: RTL

- Instruction-memory responder for the fetch stage. It is the far end of the fetch request/address interface: it takes the fetch unit's request and PC, and returns the instruction word after a fixed, parameterised latency.
- It owns a word-addressed instruction array, preloaded through a load port by the testbench or boot logic.
- It supports pipeline flush (branch redirect) and downstream hold.
- Its busy output drives the fetch unit's PC stall.

---
 rtl/inst_mem_responder.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/inst_mem_responder.sv
// Instruction-memory responder for the fetch stage.
// Holds a word-addressed instruction array that is preloaded through a load
// port. It returns the word for each accepted fetch after LATENCY cycles.
// It supports flush (branch redirect) and downstream hold.
//
// Handshake: a fetch is accepted on a rising edge where state is READY,
// inst_request=1 and hold=0. busy is the inverse of "could accept this
// cycle", so the fetch unit keeps its PC stalled and re-presents the request.
// There is no ready on the response side. inst_valid=1 marks one response.
// While hold=1 that response stays on the outputs unchanged. It is consumed
// on the first cycle with hold=0.
module inst_mem_responder #(
    parameter int              XLEN        = 32,
    parameter int              DEPTH_WORDS = 1024,
    parameter int              LATENCY     = 2,
    parameter logic [XLEN-1:0] NOP_INST    = 'h13
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           load_req,
    input  logic                           load_en,
    input  logic [$clog2(DEPTH_WORDS)-1:0] load_addr,
    input  logic [XLEN-1:0]                load_data,
    input  logic                           load_done,
    input  logic                           inst_request,
    input  logic [XLEN-1:0]                pc,
    input  logic                           flush,
    input  logic                           hold,
    output logic                           busy,
    output logic                           inst_valid,
    output logic [XLEN-1:0]                inst,
    output logic [XLEN-1:0]                inst_pc,
    output logic                           inst_fault
);

    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        READY = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Exposed by name so the FSM can be probed hierarchically.
    state_t state;
    state_t state_next;

    logic [XLEN-1:0] mem [DEPTH_WORDS];

    // Stage LATENCY-1 is the output register set.
    logic            stg_v  [LATENCY];
    logic [XLEN-1:0] stg_pc [LATENCY];
    logic            stg_f  [LATENCY];
    logic [XLEN-1:0] stg_d  [LATENCY];

    logic          accept;
    logic          fault_c;
    logic [AW-1:0] idx;
    logic          any_valid;

    assign busy    = (state != READY) | hold;
    assign accept  = (state == READY) & inst_request & ~hold;
    assign idx     = pc[AW+1:2];
    // Anything above the array (including 0xFFFFFFFC) faults; no wrap.
    assign fault_c = (pc[1:0] != 2'b00) | (pc[XLEN-1:AW+2] != '0);

    // OR of every stage valid bit, used to decide when DRAIN is finished.
    always_comb begin
        any_valid = 1'b0;
        for (int i = 0; i < LATENCY; i++) begin
            any_valid = any_valid | stg_v[i];
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= LOAD;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. A flush in DRAIN empties the pipe at this edge, so it
    // counts as drained.
    always_comb begin
        state_next = state;
        case (state)
            LOAD:    if (load_done) state_next = READY;
            READY:   if (load_req)  state_next = DRAIN;
            DRAIN:   if (!hold && (!any_valid || flush)) state_next = LOAD;
            default: state_next = LOAD;
        endcase
    end

    // Preload write port. The array is not reset.
    always_ff @(posedge clk) begin
        if (state == LOAD && load_en) begin
            mem[load_addr] <= load_data;
        end
    end

    // Response pipeline. Stage 0 does the synchronous array read. hold
    // freezes everything. flush clears valids, except that a same-cycle
    // request without hold still enters stage 0 as the redirect target.
    // Data moves only with a valid entry, so inst keeps its last value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LATENCY; i++) begin
                stg_v[i]  <= 1'b0;
                stg_pc[i] <= '0;
                stg_f[i]  <= 1'b0;
                stg_d[i]  <= NOP_INST;
            end
        end else begin
            if (flush) begin
                for (int i = 0; i < LATENCY; i++) begin
                    stg_v[i] <= 1'b0;
                end
            end
            if (!hold) begin
                stg_v[0] <= accept;
                if (accept) begin
                    stg_pc[0] <= pc;
                    stg_f[0]  <= fault_c;
                    stg_d[0]  <= fault_c ? NOP_INST : mem[idx];
                end
                for (int i = 1; i < LATENCY; i++) begin
                    if (!flush) begin
                        stg_v[i] <= stg_v[i-1];
                        if (stg_v[i-1]) begin
                            stg_pc[i] <= stg_pc[i-1];
                            stg_f[i]  <= stg_f[i-1];
                            stg_d[i]  <= stg_d[i-1];
                        end
                    end
                end
            end
        end
    end

    assign inst_valid = stg_v[LATENCY-1];
    assign inst       = stg_d[LATENCY-1];
    assign inst_pc    = stg_pc[LATENCY-1];
    assign inst_fault = stg_f[LATENCY-1];

endmodule
